// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit.
// Multiplies use a radix-2 shift-add core and divides use restoring division,
// both on operand magnitudes with sign correction applied in FIN.
// Divide-by-zero and signed overflow skip CALC and finish one cycle after acceptance.
//
// Handshake: start is sampled only while busy is low. busy is high from the
// edge after acceptance until the edge that raises done. done is a one-cycle
// pulse that never overlaps busy, and result holds until the next done.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Captured operation and operand sign information
  logic [2:0]  op;
  logic        a_neg;
  logic        b_neg;
  logic        special;
  // Multiplicand (multiply) or divisor magnitude (divide)
  logic [31:0] opnd;
  // Multiply: {product_hi, multiplier/product_lo}
  // Divide:   {remainder, dividend/quotient}
  // Special:  the precomputed result sits in the low half
  logic [63:0] acc;
  logic [5:0]  cnt;

  // Decode of the incoming request
  logic        in_div;
  logic        a_signed_in;
  logic        b_signed_in;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] special_res;

  // Iteration datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic        no_borrow;
  logic [31:0] diff;
  logic [63:0] div_next;

  // Sign correction in FIN
  logic        res_neg;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fin_res;

  // Request decode: operand signedness, magnitudes and fast-path detection
  always_comb begin
    in_div      = funct3[2];
    a_signed_in = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
    b_signed_in = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg_in    = a_signed_in & a[31];
    b_neg_in    = b_signed_in & b[31];
    a_mag       = a_neg_in ? (32'd0 - a) : a;
    b_mag       = b_neg_in ? (32'd0 - b) : b;
    div_zero    = in_div & (b == 32'd0);
    div_ovf     = in_div & ~funct3[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    special_res = 32'd0;
    if (div_zero) begin
      special_res = funct3[1] ? a : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, opnd};
    if (acc[0]) begin
      mul_next = {mul_sum, acc[31:1]};
    end else begin
      mul_next = {1'b0, acc[63:32], acc[31:1]};
    end
    rem_sh    = acc[63:31];
    no_borrow = (rem_sh >= {1'b0, opnd});
    // When there is no borrow the true difference is below the divisor,
    // so the low 32 bits of the subtraction are exact.
    diff      = rem_sh[31:0] - opnd;
    if (no_borrow) begin
      div_next = {diff, acc[30:0], 1'b1};
    end else begin
      div_next = {rem_sh[31:0], acc[30:0], 1'b0};
    end
  end

  // Final sign correction and result selection
  always_comb begin
    res_neg = a_neg ^ b_neg;
    prod    = res_neg ? (64'd0 - acc) : acc;
    quo     = res_neg ? (32'd0 - acc[31:0]) : acc[31:0];
    rem     = a_neg ? (32'd0 - acc[63:32]) : acc[63:32];
    if (!op[2]) begin
      fin_res = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end else begin
      fin_res = op[1] ? rem : quo;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (div_zero | div_ovf) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt == 6'd31) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath registers, result and done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op      <= 3'd0;
      a_neg   <= 1'b0;
      b_neg   <= 1'b0;
      special <= 1'b0;
      opnd    <= 32'd0;
      acc     <= 64'd0;
      cnt     <= 6'd0;
      done    <= 1'b0;
      result  <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op      <= funct3;
            a_neg   <= a_neg_in;
            b_neg   <= b_neg_in;
            special <= div_zero | div_ovf;
            cnt     <= 6'd0;
            opnd    <= in_div ? b_mag : a_mag;
            if (div_zero | div_ovf) begin
              acc <= {32'd0, special_res};
            end else begin
              acc <= {32'd0, (in_div ? a_mag : b_mag)};
            end
          end
        end
        S_CALC: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + 6'd1;
        end
        S_FIN: begin
          result <= special ? acc[31:0] : fin_res;
          done   <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed bench for muldiv_unit with a
// behavioural RV32M model and a scoreboard checked on every done pulse.
module tb_muldiv_unit;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .funct3 (funct3),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  longint      cyc = 0;
  int          done_seen = 0;
  logic        prev_done = 1'b0;

  logic [31:0] exp_q[$];
  int          lat_q[$];
  longint      acc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic fast_path(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f);
    return f[2] && ((y == 32'd0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] f);
    logic [63:0] ex;
    logic [63:0] ey;
    logic [63:0] p;
    int          sx;
    int          sy;
    if (!f[2]) begin
      ex = (f != 3'b011 && x[31]) ? {32'hFFFF_FFFF, x} : {32'd0, x};
      ey = (f[1] == 1'b0 && y[31]) ? {32'hFFFF_FFFF, y} : {32'd0, y};
      p  = ex * ey;
      return (f == 3'b000) ? p[31:0] : p[63:32];
    end
    if (y == 32'd0) return f[1] ? x : 32'hFFFF_FFFF;
    if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    if (f[0]) return f[1] ? (x % y) : (x / y);
    sx = x;
    sy = y;
    return f[1] ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  // ---------------- scoreboard ----------------
  // Acceptance monitor: records expected result and latency at each accepted start
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end else if (start && !busy) begin
      exp_q.push_back(model(a, b, funct3));
      lat_q.push_back(fast_path(a, b, funct3) ? 1 : 33);
      acc_q.push_back(cyc);
    end
  end

  // Compare process: checks outputs against the model every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (busy && done) begin
        n_fail++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both high", busy, done);
      end
      if (done && prev_done) begin
        n_fail++;
        $display("FAIL done_width: done high %0d cycles in a row, required 1", 2);
      end
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: result %08h with no accepted op", result);
        end else begin
          logic [31:0] e;
          int          l;
          longint      t;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          t = acc_q.pop_front();
          check("sb_result", result, e);
          check("sb_latency", 32'(cyc - t), 32'(l));
        end
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b required 0", busy);
    end
  endtask

  // Waits for done with a bounded budget; counts busy cycles on the way
  task automatic wait_done(output logic ok, inout int busy_cnt);
    int k;
    ok = 1'b0;
    for (k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: done=%0b required 1 within 45 cycles", done);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] f, input logic [31:0] exp, input int lat);
    logic ok;
    int   bc;
    wait_idle();
    a = x;
    b = y;
    funct3 = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    funct3 = 3'($urandom_range(0, 7));
    bc = busy ? 1 : 0;
    wait_done(ok, bc);
    if (ok) check(name, result, exp);
    check({name, "_busy_cycles"}, 32'(bc), 32'(lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic        ok;
    int          bc;
    int          d0;
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  f;
    int          sel;

    // Pin the model against hand-computed values
    check("model_mul", model(32'd7, 32'hFFFF_FFFD, 3'b000), 32'hFFFF_FFEB);
    check("model_mulh", model(32'h8000_0000, 32'h8000_0000, 3'b001), 32'h4000_0000);
    check("model_mulhsu", model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010), 32'hFFFF_FFFF);
    check("model_rem", model(32'hFFFF_FFF9, 32'd2, 3'b110), 32'hFFFF_FFFF);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations
    run_op("mul_7_m3",     32'd7,          32'hFFFF_FFFD, 3'b000, 32'hFFFF_FFEB, 33);
    run_op("mulh_min_min", 32'h8000_0000,  32'h8000_0000, 3'b001, 32'h4000_0000, 33);
    run_op("mulhu_max",    32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b011, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_m1",    32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFF, 33);
    run_op("div_m7_2",     32'hFFFF_FFF9,  32'd2,         3'b100, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",     32'hFFFF_FFF9,  32'd2,         3'b110, 32'hFFFF_FFFF, 33);
    run_op("divu_m7_2",    32'hFFFF_FFF9,  32'd2,         3'b101, 32'h7FFF_FFFC, 33);
    run_op("remu_m7_2",    32'hFFFF_FFF9,  32'd2,         3'b111, 32'd1,         33);
    run_op("divu_by0",     32'd5,          32'd0,         3'b101, 32'hFFFF_FFFF, 1);
    run_op("rem_by0",      32'd5,          32'd0,         3'b110, 32'd5,         1);
    run_op("div_ovf",      32'h8000_0000,  32'hFFFF_FFFF, 3'b100, 32'h8000_0000, 1);
    run_op("rem_ovf",      32'h8000_0000,  32'hFFFF_FFFF, 3'b110, 32'd0,         1);

    // Starts while busy are ignored
    wait_idle();
    a = 32'd1234; b = 32'd5678; funct3 = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 5 || k == 20) begin
        a = $urandom; b = $urandom; funct3 = 3'($urandom_range(0, 7)); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(ok, bc);
    if (ok) check("ignored_start_result", result, 32'd7006652);
    @(negedge clk);
    check("ignored_start_not_queued", {31'd0, busy}, 32'd0);

    // Back-to-back: start asserted during done
    wait_idle();
    a = 32'd3; b = 32'd5; funct3 = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    wait_done(ok, bc);
    if (ok) check("b2b_first", result, 32'd15);
    a = 32'd100; b = 32'd9; funct3 = 3'b101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = busy ? 1 : 0;
    wait_done(ok, bc);
    if (ok) check("b2b_second", result, 32'd11);
    check("b2b_busy_cycles", 32'(bc), 32'd33);

    // Reset in the middle of CALC aborts the operation
    wait_idle();
    a = 32'd1000; b = 32'd3; funct3 = 3'b100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_result", result, 32'd0);
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check("midreset_no_done", 32'(done_seen - d0), 32'd0);
    run_op("div_100_7", 32'd100, 32'd7, 3'b100, 32'd14, 33);

    // Randomized operations with biased corner operands
    repeat (150) begin
      f   = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) y = 32'd0;
      if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (sel == 2) y = 32'($urandom_range(1, 15));
      if (sel == 3) x = 32'($urandom_range(0, 3));
      run_op("random", x, y, f, model(x, y, f), fast_path(x, y, f) ? 1 : 33);
    end

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle RV32M execution unit: computes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU on 32-bit operands, selected by the same `funct3` encoding the single-cycle integer ALU uses. It sits beside that ALU in the execute stage. It is started when the decoder sees `funct7 == 7'b0000001` on an OP instruction, and it stalls the pipeline through `busy` until `done`. Normal operations are iterative (one bit per cycle). Division-by-zero and signed overflow take a single-cycle fast path.

## Interface
Parameters:
- none (width fixed at 32, iteration count fixed at 32).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request; sampled only while `busy == 0`.
- `a`  in  32  rs1 operand; captured when `start` is accepted.
- `b`  in  32  rs2 operand; captured when `start` is accepted.
- `funct3`  in  3  operation select; captured when `start` is accepted:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `busy`  out  1  high from the edge after acceptance until the edge that raises `done`.
- `done`  out  1  one-cycle pulse; `result` is valid while it is high.
- `result`  out  32  last completed result; holds until the next `done`.

## Operation
- States: IDLE, CALC, FIN.
- IDLE, `start` = 1 at an edge:
  - Latch `funct3`.
  - Form magnitudes and sign flags:
    - MUL and MULH: `a` signed, `b` signed.
    - MULHSU: `a` signed, `b` unsigned.
    - MULHU, DIVU, REMU: both operands unsigned.
    - DIV and REM: both operands signed.
  - Clear the 6-bit counter and the 64-bit accumulator/remainder.
  - If the operation is divide-by-zero or signed overflow, go directly to FIN with the special result. Otherwise go to CALC.
- CALC, multiply: shift-add, radix 2. Each cycle, if the current multiplier LSB is 1, add the multiplicand into the upper half of the 64-bit product, then shift right. Unsigned core.
- CALC, divide: restoring division. Each cycle, shift remainder:dividend left by 1. Trial-subtract the divisor magnitude. If there is no borrow, keep the difference and set the quotient bit to 1.
- The counter increments each CALC cycle. After 32 CALC cycles, go to FIN.
- FIN: apply sign correction, register `result`, pulse `done`, return to IDLE.
  - Product: negate the 64-bit value if the operand signs differ. MUL returns bits [31:0]; the MULH variants return bits [63:32].
  - Quotient: negative if the signs differ.
  - Remainder: takes the sign of the dividend.
- Special cases, evaluated on the original operands:
  - `b == 0`: DIV and DIVU return 0xFFFFFFFF; REM and REMU return `a`.
  - DIV with `a == 0x80000000` and `b == 0xFFFFFFFF`: returns 0x80000000. REM with the same operands returns 0.
- All arithmetic is modulo 2^32 (or 2^64 for the internal product). No exceptions or flags are raised.

## Timing
- Reset (`rst_n` low at an edge):
  - State goes to IDLE.
  - `busy` = 0, `done` = 0, `result` = 0x00000000.
  - The counter and datapath registers are cleared.
  - Reset mid-operation aborts the operation; no `done` is produced for it.
- Let start be accepted at edge T (IDLE, `start` = 1).
- Normal operation:
  - `busy` = 1 after T.
  - CALC occupies edges T+1 through T+32.
  - FIN occurs at edge T+33: `done` = 1 and the new `result` appear after T+33, and `busy` = 0 at the same time.
  - Latency is 33 cycles.
- Fast path: FIN occurs at edge T+1. `done` and `result` appear after T+1. `busy` is high for exactly the cycle between T and T+1.
- `done` is asserted for exactly one cycle.
- `start` while `busy` = 1 is ignored and not queued.
- `start` in the same cycle that `done` is high is accepted (the unit is back in IDLE).
- Operand or `funct3` changes after acceptance have no effect.
- `busy` and `done` are never high together.

## Test plan
- Reset, then MUL with a = 7, b = 0xFFFFFFFD (-3) -> `result` = 0xFFFFFFEB, `done` pulse exactly 33 cycles after acceptance, `busy` high for 33 cycles.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU a = 0xFFFFFFFF, b = 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed division with a = 0xFFFFFFF9 (-7), b = 2:
  - DIV -> 0xFFFFFFFD.
  - REM -> 0xFFFFFFFF.
  - DIVU -> 0x7FFFFFFC; REMU -> 1.
- Fast path, each completing 1 cycle after acceptance:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Handshake:
  - Pulse `start` with new operands at cycles 5 and 20 after an accepted MUL. Both are ignored; `result` is the first op's value.
  - Back-to-back: assert `start` during `done` -> accepted, with the second `done` 33 cycles later.
- Drop `rst_n` for one edge at CALC cycle 16 -> `busy` = 0, `done` never pulses, `result` = 0. A subsequent DIV 100/7 returns 14.
